// File: rtl/sap_clk_ctrl_pkg.sv
// Shared definitions for the SAP clock sequencer: FSM state encoding,
// default parameter values and a small parameter-clamping helper.
package sap_clk_pkg;

  typedef enum logic [2:0] {
    ST_DIVRST = 3'd0,
    ST_SETTLE = 3'd1,
    ST_IDLE   = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam int DEF_DIV_HOLD   = 8;
  localparam int DEF_SETTLE     = 16;
  localparam int DEF_RATE_W     = 24;
  localparam int DEF_DEB_CYCLES = 65535;

  // Counts configured as 0 still last one cycle.
  function automatic int min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/sap_clk_ctrl_if.sv
// Board/CPU-facing signal bundle of the clock sequencer.
// master = board/CPU side driving the controls, slave = the sequencer.
interface sap_clk_ctrl_if #(
  parameter int RATE_W = sap_clk_pkg::DEF_RATE_W
);
  logic              mode_run;
  logic              step_btn;
  logic              halt;
  logic [RATE_W-1:0] rate;
  logic              clkdiv_resetn;
  logic              cpu_ce;
  logic              cpu_clr;
  logic              ready;
  logic [2:0]        state;

  modport master (
    output mode_run, step_btn, halt, rate,
    input  clkdiv_resetn, cpu_ce, cpu_clr, ready, state
  );

  modport slave (
    input  mode_run, step_btn, halt, rate,
    output clkdiv_resetn, cpu_ce, cpu_clr, ready, state
  );
endinterface

// File: rtl/sap_clk_ctrl_debounce.sv
// Step-button conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each 0->1 change of the debounced level.
module sap_debounce
  import sap_clk_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  localparam int DEB_EFF = min1(DEB_CYCLES);
  localparam int CW      = (DEB_EFF > 1) ? $clog2(DEB_EFF) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DEB_EFF - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, the terminal count flips the level.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_TOP) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sap_clk_ctrl.sv
// SAP CPU clock sequencer: releases CLKDIV from reset, waits for it to
// settle, then issues one-cycle CPU clock enables in run or step mode.
module sap_clk_ctrl
  import sap_clk_pkg::*;
#(
  parameter int DIV_HOLD   = DEF_DIV_HOLD,
  parameter int SETTLE     = DEF_SETTLE,
  parameter int RATE_W     = DEF_RATE_W,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic          hclkin,
  input  logic          reset,
  sap_clk_ctrl_if.slave bus
);

  localparam int DH_EFF  = min1(DIV_HOLD);
  localparam int ST_EFF  = min1(SETTLE);
  localparam int CNT_MAX = (DH_EFF > ST_EFF) ? DH_EFF : ST_EFF;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DH_TOP = CNT_W'(DH_EFF - 1);
  localparam logic [CNT_W-1:0] ST_TOP = CNT_W'(ST_EFF - 1);

  logic              run_s1_q, run_s2_q;
  logic              step_lvl, step_rise, step_req;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RATE_W-1:0] pre_q, pre_d;
  logic              ce_q, ce_d;
  logic              resetn_q, resetn_d;
  logic              clr_q, clr_d;
  logic              ready_q, ready_d;

  // Synchronize the run/step mode switch.
  always_ff @(posedge hclkin or posedge reset) begin
    if (reset) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      run_s1_q <= bus.mode_run;
      run_s2_q <= run_s1_q;
    end
  end

  sap_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk_i  (hclkin),
    .rst_i  (reset),
    .din_i  (bus.step_btn),
    .level_o(step_lvl),
    .rise_o (step_rise)
  );

  assign step_req = step_rise & step_lvl;

  // Next state, sequencing counter, prescaler and registered-output values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    ce_d    = 1'b0;
    case (state_q)
      ST_DIVRST: begin
        if (cnt_q == DH_TOP) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == ST_TOP) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.halt) begin
          state_d = ST_HALT;
        end else if (run_s2_q) begin
          state_d = ST_RUN;
          pre_d   = bus.rate;
        end else if (step_req) begin
          ce_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Halt and leaving run mode both take priority over a due pulse.
        if (bus.halt) begin
          state_d = ST_HALT;
        end else if (!run_s2_q) begin
          state_d = ST_IDLE;
        end else if (pre_q == '0) begin
          ce_d  = 1'b1;
          pre_d = bus.rate;
        end else begin
          pre_d = pre_q - RATE_W'(1);
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_DIVRST;
    endcase
    resetn_d = (state_d != ST_DIVRST);
    ready_d  = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_HALT);
    clr_d    = !ready_d;
  end

  // State and output registers; reset drops any pulse in flight.
  always_ff @(posedge hclkin or posedge reset) begin
    if (reset) begin
      state_q  <= ST_DIVRST;
      cnt_q    <= '0;
      pre_q    <= '0;
      ce_q     <= 1'b0;
      resetn_q <= 1'b0;
      clr_q    <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      ce_q     <= ce_d;
      resetn_q <= resetn_d;
      clr_q    <= clr_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.clkdiv_resetn = resetn_q;
  assign bus.cpu_ce        = ce_q;
  assign bus.cpu_clr       = clr_q;
  assign bus.ready         = ready_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_sap_clk_ctrl.sv
// Bench for sap_clk_ctrl: directed sequences, a run-rate vector table and
// randomized episodes, all shadowed by a cycle-level reference model.
module tb_sap_clk_ctrl;
  import sap_clk_pkg::*;

  localparam int DH  = 8;
  localparam int ST  = 16;
  localparam int DEB = 4;
  localparam int RW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sap_clk_ctrl_if #(.RATE_W(RW)) ifc ();

  sap_clk_ctrl #(
    .DIV_HOLD(DH), .SETTLE(ST), .RATE_W(RW), .DEB_CYCLES(DEB)
  ) dut (
    .hclkin(clk),
    .reset (rst),
    .bus   (ifc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: time since reset release, input histories and the
  // "due time" of the next run pulse instead of a down-counter.
  int     m_t = 0;
  int     m_due = 0;
  state_e m_st = ST_DIVRST;
  logic   m_deb = 1'b0, m_rise = 1'b0, m_ce = 1'b0;
  logic   sq[$];
  logic   mq[$];

  always @(posedge clk) begin
    logic msync, v, stable, nd;
    if (rst) begin
      m_t = 0; m_due = 0; m_st = ST_DIVRST;
      m_deb = 1'b0; m_rise = 1'b0; m_ce = 1'b0;
      sq.delete(); mq.delete();
      for (int i = 0; i < DEB + 2; i++) begin sq.push_back(1'b0); mq.push_back(1'b0); end
    end else begin
      m_t++;
      sq.push_front(ifc.step_btn); void'(sq.pop_back());
      mq.push_front(ifc.mode_run); void'(mq.pop_back());
      msync = mq[2];
      m_ce  = 1'b0;
      if (m_t < DH) m_st = ST_DIVRST;
      else if (m_t < DH + ST) m_st = ST_SETTLE;
      else if (m_t == DH + ST) m_st = ST_IDLE;
      else if (m_st == ST_IDLE) begin
        if (ifc.halt) m_st = ST_HALT;
        else if (msync) begin m_st = ST_RUN; m_due = m_t + int'(ifc.rate) + 1; end
        else if (m_rise) m_ce = 1'b1;
      end else if (m_st == ST_RUN) begin
        if (ifc.halt) m_st = ST_HALT;
        else if (!msync) m_st = ST_IDLE;
        else if (m_t == m_due) begin m_ce = 1'b1; m_due = m_t + int'(ifc.rate) + 1; end
      end
      // Debounced level: a value seen on the last DEB synchronized samples.
      v = sq[2]; stable = 1'b1;
      for (int i = 2; i < DEB + 2; i++) if (sq[i] != v) stable = 1'b0;
      nd     = stable ? v : m_deb;
      m_rise = nd & !m_deb;
      m_deb  = nd;
    end
  end

  // Scoreboard: every cycle, all outputs against the model.
  always @(posedge clk) begin
    logic [6:0] act, exp;
    #1;
    exp = {(m_t >= DH), m_ce, !(m_t >= DH + ST), (m_t >= DH + ST), m_st};
    act = {ifc.clkdiv_resetn, ifc.cpu_ce, ifc.cpu_clr, ifc.ready, ifc.state};
    chk("sb", int'(act), int'(exp));
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_resetn"}, ifc.clkdiv_resetn, 0);
    chk({nm, "_ce"},     ifc.cpu_ce, 0);
    chk({nm, "_clr"},    ifc.cpu_clr, 1);
    chk({nm, "_ready"},  ifc.ready, 0);
    chk({nm, "_state"},  ifc.state, ST_DIVRST);
  endtask

  task automatic powerup();
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("pwr_resetn", ifc.clkdiv_resetn, (k >= DH) ? 1 : 0);
      chk("pwr_ready",  ifc.ready, (k >= DH + ST) ? 1 : 0);
      chk("pwr_clr",    ifc.cpu_clr, (k >= DH + ST) ? 0 : 1);
      chk("pwr_ce",     ifc.cpu_ce, 0);
      chk("pwr_state",  ifc.state, (k < DH) ? ST_DIVRST : (k < DH + ST) ? ST_SETTLE : ST_IDLE);
    end
  endtask

  task automatic wait_ce(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (ifc.cpu_ce) break;
    end
    chk("wait_ce", ifc.cpu_ce, 1);
  endtask

  typedef struct {
    int rate;
    int win;
    int exp_pulses;
  } run_vec_t;
  run_vec_t tbl[5];

  initial begin
    int pulses;
    tbl[0] = '{3, 20, 4};
    tbl[1] = '{0, 10, 9};
    tbl[2] = '{1, 11, 5};
    tbl[3] = '{7, 25, 3};
    tbl[4] = '{2,  4, 1};
    ifc.mode_run = 1'b0; ifc.step_btn = 1'b0; ifc.halt = 1'b0; ifc.rate = 8'd3;
    repeat (2) @(negedge clk);

    powerup();

    // Run-rate vectors: pulses seen from mode_run=1 until back in IDLE.
    for (int i = 0; i < 5; i++) begin
      pulses = 0;
      ifc.rate = RW'(tbl[i].rate);
      ifc.mode_run = 1'b1;
      for (int k = 1; k <= tbl[i].win; k++) begin @(negedge clk); if (ifc.cpu_ce) pulses++; end
      ifc.mode_run = 1'b0;
      for (int k = 1; k <= 3; k++) begin @(negedge clk); if (ifc.cpu_ce) pulses++; end
      chk("run_cnt", pulses, tbl[i].exp_pulses);
      chk("run_idle", ifc.state, ST_IDLE);
    end

    // Rate change mid-period: current period (4) finishes, then every cycle.
    ifc.rate = 8'd3; ifc.mode_run = 1'b1;
    wait_ce(20);
    ifc.rate = 8'd0;
    for (int k = 1; k <= 6; k++) begin @(negedge clk); chk("rate_chg", ifc.cpu_ce, (k >= 4) ? 1 : 0); end
    ifc.mode_run = 1'b0;
    repeat (3) @(negedge clk);
    chk("rate_idle", ifc.state, ST_IDLE);
    ifc.rate = 8'd3;

    // Bouncy press: 1/0/1 then held; one pulse 7 cycles after the final rise.
    repeat (4) @(negedge clk);
    ifc.step_btn = 1'b1; @(negedge clk);
    ifc.step_btn = 1'b0; @(negedge clk);
    ifc.step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin @(negedge clk); chk("step1", ifc.cpu_ce, (k == 7) ? 1 : 0); end
    ifc.step_btn = 1'b0;
    for (int k = 1; k <= 8; k++) begin @(negedge clk); chk("step_rel", ifc.cpu_ce, 0); end
    ifc.step_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin @(negedge clk); chk("step2", ifc.cpu_ce, (k == 7) ? 1 : 0); end
    ifc.step_btn = 1'b0;
    repeat (8) @(negedge clk);

    // Halt in the cycle the prescaler expires: no pulse, HALT next.
    ifc.rate = 8'd3; ifc.mode_run = 1'b1;
    wait_ce(20);
    repeat (3) @(negedge clk);
    ifc.halt = 1'b1;
    @(negedge clk);
    chk("halt_ce", ifc.cpu_ce, 0);
    chk("halt_state", ifc.state, ST_HALT);
    ifc.halt = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k % 6 == 0) ifc.mode_run = ~ifc.mode_run;
      if (k % 10 == 0) ifc.step_btn = ~ifc.step_btn;
      @(negedge clk);
      chk("halt_ce_hold", ifc.cpu_ce, 0);
      chk("halt_st_hold", ifc.state, ST_HALT);
    end
    ifc.step_btn = 1'b0; ifc.mode_run = 1'b0;
    powerup();

    // Reset during RUN with the prescaler at 2.
    ifc.rate = 8'd3; ifc.mode_run = 1'b1;
    wait_ce(20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    ifc.mode_run = 1'b0;
    powerup();

    // Leave RUN; a press debounced during RUN is not replayed in IDLE.
    ifc.rate = 8'd3; ifc.mode_run = 1'b1;
    repeat (4) @(negedge clk);
    ifc.step_btn = 1'b1;
    repeat (10) @(negedge clk);
    ifc.mode_run = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 2) chk("tog_run", ifc.state, ST_RUN);
      if (k == 3) chk("tog_idle", ifc.state, ST_IDLE);
      if (k >= 3) chk("tog_no_replay", ifc.cpu_ce, 0);
    end
    ifc.step_btn = 1'b0;

    // Randomized episodes, checked by the scoreboard only.
    for (int ep = 0; ep < 6; ep++) begin
      rst = 1'b1;
      ifc.mode_run = 1'b0; ifc.step_btn = 1'b0; ifc.halt = 1'b0;
      ifc.rate = RW'($urandom_range(0, 6));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 29) == 0) ifc.mode_run = ~ifc.mode_run;
        if ($urandom_range(0, 5) == 0) ifc.step_btn = ~ifc.step_btn;
        if ($urandom_range(0, 19) == 0) ifc.rate = RW'($urandom_range(0, 6));
        ifc.halt = ($urandom_range(0, 299) == 0);
      end
    end
    ifc.halt = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
